uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART byte transmitter (UartTxEn-style: data, one-cycle valid pulse, one-cycle done pulse) among NumReq on-chip requesters. A requester holds a packet lock until its last byte or until MaxBurst bytes have gone out. A watchdog aborts a byte if the transmitter never reports done. It sits between requester FIFOs and the transmitter, upstream of the baud-rate generator.

Parameters:
NumReq, 4, number of requesters (2..8)
MaxBurst, 16, maximum bytes one owner sends before a forced re-arbitration
TimeoutWidth, 24, width of the watchdog counter and of timeout_limit

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  NumReq  requester i presents a byte
req_data  input  NumReq*8  byte of requester i at bits [8i+7:8i]
req_last  input  NumReq  presented byte is the final byte of its packet
req_ready  output  NumReq  combinational; a byte transfers when valid and ready are both high
tx_data  output  8  registered byte to the transmitter
tx_valid  output  1  one-cycle start pulse to the transmitter
tx_done  input  1  one-cycle pulse from the transmitter when the byte has finished
timeout_limit  input  TimeoutWidth  watchdog limit in cycles; 0 disables the watchdog
err_clr  input  1  clears timeout_err
grant  output  NumReq  one-hot current owner, 0 when unowned
busy  output  1  high whenever state is not IDLE
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset values: state IDLE; tx_data 0; tx_valid 0; grant 0; busy 0; timeout_err 0; rr pointer 0; burst count 0; watchdog 0. req_ready is 0 in reset.
- Requester rule: a requester holds req_data and req_last stable while req_valid is high and it has not yet been accepted.
- States: IDLE, HOLD, START, WAIT.
- IDLE:
  - Pick the first i with req_valid, searching from the pointer upward modulo NumReq.
  - req_ready[i] is high in that same cycle.
  - On transfer: tx_data is loaded, grant becomes onehot(i), burst count becomes 1, last flag is captured, next state is START.
- HOLD:
  - Only the owner may transfer; req_ready equals grant & req_valid.
  - On transfer: increment the burst count, then go to START.
  - The watchdog also runs in HOLD. If the owner has presented nothing after timeout_limit cycles, release the lock and go to IDLE. This is not an error.
- START: tx_valid = 1 for exactly one cycle; clear the watchdog; go to WAIT.
- WAIT: the watchdog increments each cycle.
  - If tx_done arrives:
    - If the last flag is set or burst count == MaxBurst: release (grant 0, pointer = owner+1 mod NumReq, burst count 0) and go to IDLE.
    - Otherwise go to HOLD.
  - Else if timeout_limit != 0 and the watchdog has reached timeout_limit: set timeout_err, release as above, go to IDLE.
- Latency: acceptance in cycle t gives tx_valid in t+1. tx_done in cycle d allows the next acceptance at d+1 at the earliest.
- Simultaneous events:
  - tx_done and timeout in the same cycle: done wins, no error.
  - err_clr and timeout-set in the same cycle: set wins.
- tx_done seen in IDLE, HOLD or START is ignored.
- A forced MaxBurst release without last leaves the packet unfinished. The owner re-arbitrates normally afterwards.
- The pointer advances only on release, never per byte.
- Reset mid-operation aborts the byte in flight and returns to the reset values. The transmitter shares the same reset.

Decomposition:
- Package uart_sched_pkg: state enum (IDLE, HOLD, START, WAIT), byte width constant 8, helper function for burst-count width $clog2(MaxBurst+1).
- Sub-module uart_rr_pick: purely combinational round-robin picker with inputs req vector and pointer, outputs one-hot pick and a found flag.

Test Plan:
- NumReq=4, req0 sends 0x41 then 0x42 with last on 0x42, tx_done 20 cycles after each tx_valid -> two tx_valid pulses carrying 0x41 and 0x42; grant stays 0001 throughout; afterwards grant is 0, busy is 0, pointer is 1.
- Pointer 0, req1 and req2 each valid with a single-byte packet (last=1) -> req1 is served first, then req2; pointer ends at 3.
- req0 is mid-packet and req3 becomes valid -> req_ready[3] stays 0 until req0's last byte receives tx_done; req3 is then granted at d+1.
- MaxBurst=4, req0 streams 6 bytes with no last, req1 pending -> after the 4th tx_done grant becomes 0010; req0 resumes after req1's packet.
- timeout_limit=10, tx_done never arrives -> timeout_err rises on the 10th WAIT cycle, state returns to IDLE, grant is 0; err_clr pulse clears the flag; err_clr together with a new timeout keeps the flag at 1.
- reset asserted during WAIT -> next cycle tx_valid, grant, busy and timeout_err are all 0; a following request is accepted normally.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } sched_state_e;

    // Width needed to count 0..max_burst bytes inside one ownership period.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester at or above the pointer, wrapping.
module uart_rr_pick import uart_sched_pkg::*; #(
    parameter int NumReq = 4,
    parameter int PtrW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] pick_o,
    output logic              found_o
);

    // Scan NumReq slots starting at the pointer; the first hit wins.
    always_comb begin
        int idx;
        pick_o  = '0;
        found_o = 1'b0;
        idx     = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(ptr_i) + k) % NumReq;
            if (!found_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among NumReq requesters.
// Handshake: requester i transfers a byte in any cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational and never depends on
// anything but current state and req_valid. The transmitter side is a
// one-cycle tx_valid start pulse answered later by a one-cycle tx_done pulse.
module uart_tx_scheduler import uart_sched_pkg::*; #(
    parameter int NumReq       = 4,
    parameter int MaxBurst     = 16,
    parameter int TimeoutWidth = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NumReq-1:0]        req_valid,
    input  logic [NumReq*BYTE_W-1:0] req_data,
    input  logic [NumReq-1:0]        req_last,
    output logic [NumReq-1:0]        req_ready,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_done,
    input  logic [TimeoutWidth-1:0]  timeout_limit,
    input  logic                     err_clr,
    output logic [NumReq-1:0]        grant,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int BurstW = burst_cnt_w(MaxBurst);

    sched_state_e            state_q;
    logic [BYTE_W-1:0]       tx_data_q;
    logic                    tx_valid_q;
    logic [NumReq-1:0]       grant_q;
    logic [PtrW-1:0]         ptr_q;
    logic [PtrW-1:0]         owner_q;
    logic [BurstW-1:0]       burst_q;
    logic [TimeoutWidth-1:0] wdog_q;
    logic                    last_q;
    logic                    timeout_err_q;

    logic [NumReq-1:0]       pick;
    logic                    pick_found;
    logic [PtrW-1:0]         pick_idx;
    logic [PtrW-1:0]         sel_idx;
    logic [BYTE_W-1:0]       sel_data;
    logic                    sel_last;
    logic                    xfer;
    logic [TimeoutWidth:0]   wdog_d;
    logic                    wdog_hit;
    logic                    burst_full;
    logic [PtrW-1:0]         ptr_d;
    logic                    set_err;

    uart_rr_pick #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .found_o (pick_found)
    );

    // Convert the one-hot pick into an index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (pick[i]) pick_idx = PtrW'(i);
        end
    end

    // Offer ready to the picked requester in IDLE, or to the lock owner in HOLD.
    always_comb begin
        req_ready = '0;
        if (!reset) begin
            case (state_q)
                IDLE:    req_ready = pick & {NumReq{pick_found}};
                HOLD:    req_ready = grant_q & req_valid;
                default: req_ready = '0;
            endcase
        end
    end

    // Byte source, watchdog compare, burst limit and release pointer.
    always_comb begin
        sel_idx    = (state_q == IDLE) ? pick_idx : owner_q;
        sel_data   = req_data[sel_idx*BYTE_W +: BYTE_W];
        sel_last   = req_last[sel_idx];
        xfer       = |req_ready;
        wdog_d     = {1'b0, wdog_q} + 1'b1;
        wdog_hit   = (timeout_limit != '0) && (wdog_d >= {1'b0, timeout_limit});
        burst_full = (burst_q == BurstW'(MaxBurst));
        ptr_d      = (owner_q == PtrW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
        set_err    = (state_q == WAIT) && !tx_done && wdog_hit;
    end

    // Main scheduler FSM with registered transmitter-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            grant_q       <= '0;
            ptr_q         <= '0;
            owner_q       <= '0;
            burst_q       <= '0;
            wdog_q        <= '0;
            last_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (set_err) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        tx_data_q  <= sel_data;
                        grant_q    <= pick;
                        owner_q    <= pick_idx;
                        burst_q    <= BurstW'(1);
                        last_q     <= sel_last;
                        tx_valid_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        tx_data_q  <= sel_data;
                        burst_q    <= burst_q + 1'b1;
                        last_q     <= sel_last;
                        tx_valid_q <= 1'b1;
                        state_q    <= START;
                    end else if (wdog_hit) begin
                        // Owner went quiet mid-packet: give the lock up silently.
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        burst_q <= '0;
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_d[TimeoutWidth-1:0];
                    end
                end
                START: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (tx_done) begin
                        if (last_q || burst_full) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                            burst_q <= '0;
                            wdog_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            wdog_q  <= '0;
                            state_q <= HOLD;
                        end
                    end else if (wdog_hit) begin
                        // Transmitter never answered: abort the byte and release.
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                        burst_q <= '0;
                        wdog_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_d[TimeoutWidth-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a packet-level scheduling model.
module tb_uart_tx_scheduler;

    localparam int NumReq = 4;
    localparam int MaxBurst = 4;
    localparam int TW = 24;
    localparam int EXP_W = 10;

    logic                clk;
    logic                reset;
    logic [NumReq-1:0]   req_valid;
    logic [NumReq*8-1:0] req_data;
    logic [NumReq-1:0]   req_last;
    logic [NumReq-1:0]   req_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_done;
    logic [TW-1:0]       timeout_limit;
    logic                err_clr;
    logic [NumReq-1:0]   grant;
    logic                busy;
    logic                timeout_err;

    uart_tx_scheduler #(.NumReq(NumReq), .MaxBurst(MaxBurst), .TimeoutWidth(TW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_done(tx_done), .timeout_limit(timeout_limit),
        .err_clr(err_clr), .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester queues ({last, byte}) and expected transmit order ({owner, byte})
    logic [8:0]       rq[NumReq][$];
    logic [EXP_W-1:0] exp_q[$];
    int mptr;
    int n_checks, n_pass;
    int pend, tx_lo, tx_hi;
    bit tx_never;
    bit inj_en;
    int inj_req, inj_at;
    logic [8:0] inj_val;

    logic [NumReq-1:0] obs_ready, obs_xfer, obs_grant, obs_valid;
    logic obs_tv, obs_busy, obs_err, obs_done, obs_rst;
    logic [7:0] obs_data;

    // Drivers
    task automatic drive_reqs();
        logic [8:0] h;
        for (int i = 0; i < NumReq; i++) begin
            if (rq[i].size() != 0) begin
                h = rq[i][0];
                req_valid[i] = 1'b1;
                req_data[i*8 +: 8] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // One clock: sample at the falling edge, update requesters and transmitter after the rising edge.
    task automatic step();
        @(negedge clk);
        obs_ready = req_ready;
        obs_valid = req_valid;
        obs_xfer  = req_valid & req_ready;
        obs_grant = grant;
        obs_tv    = tx_valid;
        obs_data  = tx_data;
        obs_busy  = busy;
        obs_err   = timeout_err;
        obs_done  = tx_done;
        obs_rst   = reset;
        @(posedge clk);
        #1;
        for (int i = 0; i < NumReq; i++) begin
            if (obs_xfer[i]) void'(rq[i].pop_front());
        end
        tx_done = 1'b0;
        if (obs_rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done = 1'b1;
            end
            if (obs_tv && !tx_never) begin
                pend = int'($urandom_range(tx_hi, tx_lo)) - 1;
                if (pend == 0) tx_done = 1'b1;
            end
        end
        drive_reqs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        mptr = 0;
    endtask

    task automatic wait_tv(input int lim, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            step();
            seen = obs_tv;
        end
    endtask

    // Reference model: whole packets/bursts in round-robin order from the model pointer.
    task automatic model_build();
        logic [8:0] q[NumReq][$];
        logic [8:0] e;
        int owner, n;
        bit found;
        for (int i = 0; i < NumReq; i++) q[i] = rq[i];
        forever begin
            found = 1'b0;
            owner = 0;
            for (int k = 0; k < NumReq; k++) begin
                if (!found && q[(mptr + k) % NumReq].size() != 0) begin
                    found = 1'b1;
                    owner = (mptr + k) % NumReq;
                end
            end
            if (!found) break;
            n = 0;
            do begin
                e = q[owner].pop_front();
                exp_q.push_back({owner[1:0], e[7:0]});
                n++;
            end while (!e[8] && n < MaxBurst && q[owner].size() != 0);
            mptr = (owner + 1) % NumReq;
        end
    endtask

    // Scoreboard run: drains exp_q and checks order, owner, latency and lock exclusivity.
    task automatic run_and_score(input string name, input int max_cyc);
        logic [EXP_W-1:0] e;
        logic [NumReq-1:0] oh;
        bit prev_xfer, prev_done, in_flight;
        int n, tv_cnt, own;
        n = 0; tv_cnt = 0; prev_xfer = 0; prev_done = 0; in_flight = 0;
        while (n < max_cyc) begin
            step();
            n++;
            if (prev_xfer || obs_tv) begin
                n_checks++;
                if (obs_tv !== prev_xfer)
                    $display("FAIL %s_latency: tx_valid=%0b after accept=%0b", name, obs_tv, prev_xfer);
                else n_pass++;
            end
            if (prev_done && exp_q.size() != 0) begin
                e = exp_q[0];
                own = int'(e[9:8]);
                if (obs_valid[own]) begin
                    oh = '0;
                    oh[own] = 1'b1;
                    n_checks++;
                    if (obs_xfer !== oh)
                        $display("FAIL %s_next_accept: xfer %b expected %b", name, obs_xfer, oh);
                    else n_pass++;
                end
            end
            if (obs_tv) begin
                in_flight = 1'b1;
                tv_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_extra_byte: got %h expected none", name, obs_data);
                end else begin
                    n_pass++;
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e[9:8]] = 1'b1;
                    n_checks++;
                    if (obs_data !== e[7:0])
                        $display("FAIL %s_data: got %h expected %h", name, obs_data, e[7:0]);
                    else n_pass++;
                    n_checks++;
                    if (obs_grant !== oh)
                        $display("FAIL %s_grant: got %b expected %b", name, obs_grant, oh);
                    else n_pass++;
                end
                if (inj_en && tv_cnt == inj_at) begin
                    rq[inj_req].push_back(inj_val);
                    drive_reqs();
                    inj_en = 1'b0;
                end
            end
            if (obs_grant != '0) begin
                n_checks++;
                if ((obs_ready & ~obs_grant) !== '0)
                    $display("FAIL %s_lock: ready %b grant %b", name, obs_ready, obs_grant);
                else n_pass++;
            end
            if (in_flight) begin
                n_checks++;
                if (obs_ready !== '0)
                    $display("FAIL %s_ready_in_flight: got %b expected 0", name, obs_ready);
                else n_pass++;
            end
            if (obs_done) in_flight = 1'b0;
            prev_xfer = |obs_xfer;
            prev_done = obs_done;
            if (exp_q.size() == 0 && !obs_busy && !in_flight) break;
        end
        n_checks++;
        if (exp_q.size() != 0 || obs_busy !== 1'b0)
            $display("FAIL %s_drain: left %0d bytes busy=%0b expected 0 and 0", name, exp_q.size(), obs_busy);
        else n_pass++;
        n_checks++;
        if (obs_grant !== '0 || obs_err !== 1'b0)
            $display("FAIL %s_end_state: grant %b err %0b expected 0 0", name, obs_grant, obs_err);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NumReq; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
        drive_reqs();
        step();
        step();
        n_checks++;
        if (obs_ready !== '0 || obs_tv !== 1'b0 || obs_data !== 8'h00)
            $display("FAIL reset_outputs: ready %b tv %0b data %h expected 0", obs_ready, obs_tv, obs_data);
        else n_pass++;
        n_checks++;
        if (obs_grant !== '0 || obs_busy !== 1'b0 || obs_err !== 1'b0)
            $display("FAIL reset_status: grant %b busy %0b err %0b expected 0", obs_grant, obs_busy, obs_err);
        else n_pass++;
        for (int i = 0; i < NumReq; i++) rq[i].delete();
        drive_reqs();
        reset = 1'b0;
        mptr = 0;
        step();
        n_checks++;
        if (obs_busy !== 1'b0 || obs_grant !== '0)
            $display("FAIL reset_release: busy %0b grant %b expected 0", obs_busy, obs_grant);
        else n_pass++;
    endtask

    task automatic test_two_bytes();
        timeout_limit = '0;
        tx_lo = 20; tx_hi = 20;
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b1, 8'h42});
        drive_reqs();
        model_build();
        run_and_score("two_bytes", 200);
    endtask

    task automatic test_round_robin();
        tx_lo = 2; tx_hi = 6;
        rq[0].push_back({1'b1, 8'h01});
        rq[1].push_back({1'b1, 8'h11});
        drive_reqs();
        model_build();
        run_and_score("rr_after_first", 100);
        do_reset();
        rq[1].push_back({1'b1, 8'h21});
        rq[2].push_back({1'b1, 8'h22});
        drive_reqs();
        model_build();
        run_and_score("rr_ptr0", 100);
        rq[0].push_back({1'b1, 8'h30});
        rq[3].push_back({1'b1, 8'h33});
        drive_reqs();
        model_build();
        run_and_score("rr_ptr3", 100);
    endtask

    task automatic test_lock();
        tx_lo = 10; tx_hi = 10;
        rq[0].push_back({1'b0, 8'hA0});
        rq[0].push_back({1'b0, 8'hA1});
        rq[0].push_back({1'b1, 8'hA2});
        drive_reqs();
        model_build();
        exp_q.push_back({2'd3, 8'hD3});
        mptr = 0;
        inj_en = 1'b1; inj_req = 3; inj_at = 1; inj_val = {1'b1, 8'hD3};
        run_and_score("lock", 200);
    endtask

    task automatic test_max_burst();
        timeout_limit = TW'(30);
        tx_lo = 5; tx_hi = 5;
        for (int k = 0; k < 6; k++) rq[0].push_back({1'b0, 8'(8'h50 + k)});
        rq[1].push_back({1'b0, 8'h61});
        rq[1].push_back({1'b1, 8'h62});
        drive_reqs();
        model_build();
        run_and_score("max_burst", 400);
    endtask

    task automatic test_random();
        int npk, len;
        timeout_limit = TW'(200);
        tx_lo = 1; tx_hi = 8;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NumReq; i++) begin
                npk = int'($urandom_range(2, 0));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(6, 1));
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
            end
            drive_reqs();
            model_build();
            run_and_score("random", 3000);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        timeout_limit = TW'(10);
        tx_lo = 10; tx_hi = 10;
        rq[1].push_back({1'b1, 8'h77});
        drive_reqs();
        model_build();
        run_and_score("done_at_limit", 100);

        tx_never = 1'b1;
        rq[2].push_back({1'b1, 8'hA5});
        drive_reqs();
        wait_tv(20, seen);
        n_checks++;
        if (!seen) $display("FAIL to_start: tx_valid 0 expected 1"); else n_pass++;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_checks++;
            if (obs_err !== 1'b0 || obs_busy !== 1'b1)
                $display("FAIL to_wait_%0d: err %0b busy %0b expected 0 1", k, obs_err, obs_busy);
            else n_pass++;
        end
        step();
        n_checks++;
        if (obs_err !== 1'b1 || obs_grant !== '0 || obs_busy !== 1'b0)
            $display("FAIL to_fire: err %0b grant %b busy %0b expected 1 0 0", obs_err, obs_grant, obs_busy);
        else n_pass++;
        mptr = 3;

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        n_checks++;
        if (obs_err !== 1'b0) $display("FAIL err_clr: got %0b expected 0", obs_err); else n_pass++;

        rq[3].push_back({1'b1, 8'hB6});
        drive_reqs();
        wait_tv(20, seen);
        for (int k = 1; k <= 9; k++) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        n_checks++;
        if (obs_err !== 1'b1 || obs_busy !== 1'b0)
            $display("FAIL set_beats_clr: err %0b busy %0b expected 1 0", obs_err, obs_busy);
        else n_pass++;
        mptr = 0;

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        tx_never = 1'b0;
        tx_lo = 12; tx_hi = 12;
        rq[0].push_back({1'b1, 8'hC7});
        drive_reqs();
        wait_tv(20, seen);
        n_checks++;
        if (obs_err !== 1'b0) $display("FAIL err_cleared: got %0b expected 0", obs_err); else n_pass++;
        for (int k = 1; k <= 11; k++) step();
        n_checks++;
        if (obs_err !== 1'b1 || obs_busy !== 1'b0 || obs_grant !== '0)
            $display("FAIL late_done_to: err %0b busy %0b grant %b expected 1 0 0", obs_err, obs_busy, obs_grant);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (obs_busy !== 1'b0 || obs_tv !== 1'b0)
                $display("FAIL late_done_ignored: busy %0b tv %0b expected 0 0", obs_busy, obs_tv);
            else n_pass++;
        end
        mptr = 1;
    endtask

    task automatic test_reset_mid();
        bit seen;
        timeout_limit = '0;
        tx_never = 1'b1;
        rq[1].push_back({1'b1, 8'h5A});
        drive_reqs();
        wait_tv(20, seen);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mptr = 0;
        step();
        n_checks++;
        if (obs_tv !== 1'b0 || obs_grant !== '0 || obs_busy !== 1'b0 || obs_err !== 1'b0)
            $display("FAIL reset_mid: tv %0b grant %b busy %0b err %0b expected 0", obs_tv, obs_grant, obs_busy, obs_err);
        else n_pass++;
        tx_never = 1'b0;
        tx_lo = 3; tx_hi = 3;
        rq[2].push_back({1'b1, 8'hC3});
        drive_reqs();
        model_build();
        run_and_score("after_reset", 100);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_done = 1'b0;
        timeout_limit = '0;
        err_clr = 1'b0;
        n_checks = 0; n_pass = 0;
        pend = 0; tx_lo = 1; tx_hi = 1; tx_never = 1'b0;
        inj_en = 1'b0; inj_req = 0; inj_at = 0; inj_val = '0;
        mptr = 0;
        test_reset();
        test_two_bytes();
        test_round_robin();
        test_lock();
        test_max_burst();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
